carry_accumulator: RTL and testbench

- Sequential accumulation stage built around the 16-bit carry-select adder datapath.
- Consumes a burst of COUNT operands over a valid/ready handshake and adds each into a running 16-bit sum.
- Counts carry-outs from every addition into a separate carry counter.
- Presents the final {CarryCount, Result} pair on an output valid/ready handshake to the downstream consumer.

---
 rtl/carry_accumulator.sv | 119 +++++++++++
 tb/tb_carry_accumulator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_accumulator.sv
// carry_accumulator
//   Accumulates a burst of COUNT operands into a WIDTH-bit running sum using
//   a carry-select adder, counts the carry-outs of every addition, and then
//   presents {CarryCount, Result, Overflow} on a valid/ready handshake.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a burst (sampled in IDLE only)
//   operand         next operand to accumulate
//   operandValid    operand valid this cycle
//   operandReady    block accepts an operand this cycle (ACCUM only)
//   Result          accumulator register (visible in every state)
//   CarryCount      carry-outs seen during the burst (saturating)
//   Overflow        sticky: a carry arrived while CarryCount was saturated
//   resultValid     outputs are final (DONE)
//   resultReady     downstream accepts the result
//   busy            high in ACCUM and DONE
module carry_accumulator #(
  parameter int WIDTH = 16,
  parameter int COUNT = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic             operandValid,
  output logic             operandReady,
  output logic [WIDTH-1:0] Result,
  output logic [CNT_W-1:0] CarryCount,
  output logic             Overflow,
  output logic             resultValid,
  input  logic             resultReady,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Split point of the carry-select adder.
  localparam int LO = WIDTH / 2;
  localparam int HI = WIDTH - LO;

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cc;
  logic             r_ov;
  logic [7:0]       r_cnt;

  logic [LO:0]      w_lo;
  logic [HI:0]      w_hi0;
  logic [HI:0]      w_hi1;
  logic [HI:0]      w_hi;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_hs;

  // Carry-select: both upper-half sums are formed in parallel with the lower
  // half, and the lower-half carry picks one of them.
  always_comb begin
    w_lo    = {1'b0, r_acc[LO-1:0]} + {1'b0, operand[LO-1:0]};
    w_hi0   = {1'b0, r_acc[WIDTH-1:LO]} + {1'b0, operand[WIDTH-1:LO]};
    w_hi1   = w_hi0 + (HI+1)'(1);
    w_hi    = w_lo[LO] ? w_hi1 : w_hi0;
    w_sum   = {w_hi[HI-1:0], w_lo[LO-1:0]};
    w_carry = w_hi[HI];
  end

  assign operandReady = (r_state == S_ACCUM);
  assign resultValid  = (r_state == S_DONE);
  assign busy         = (r_state == S_ACCUM) || (r_state == S_DONE);
  assign w_hs         = operandValid && operandReady;

  assign Result     = r_acc;
  assign CarryCount = r_cc;
  assign Overflow   = r_ov;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cc    <= '0;
      r_ov    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_cc    <= '0;
            r_ov    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_hs) begin
            r_acc <= w_sum;
            if (w_carry) begin
              // Saturate the carry counter; Overflow stays set until next start.
              if (r_cc == '1) r_ov <= 1'b1;
              else            r_cc <= r_cc + CNT_W'(1);
            end
            if (r_cnt == LAST) r_state <= S_DONE;
            else               r_cnt   <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          if (resultReady) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carry_accumulator.sv
module tb_carry_accumulator;

  logic clk;
  logic rst;

  // Instance 0: defaults. Instance 1: CNT_W=2, COUNT=5. Instance 2: COUNT=1.
  logic        start [3];
  logic [15:0] op    [3];
  logic        opv   [3];
  logic        opr   [3];
  logic [15:0] res   [3];
  logic [7:0]  cc    [3];
  logic        ov    [3];
  logic        rv    [3];
  logic        rr    [3];
  logic        busy  [3];
  logic [1:0]  cc_b;

  assign cc[1] = {6'b0, cc_b};

  carry_accumulator #(.WIDTH(16), .COUNT(4), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .operand(op[0]),
    .operandValid(opv[0]), .operandReady(opr[0]), .Result(res[0]),
    .CarryCount(cc[0]), .Overflow(ov[0]), .resultValid(rv[0]),
    .resultReady(rr[0]), .busy(busy[0]));

  carry_accumulator #(.WIDTH(16), .COUNT(5), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .operand(op[1]),
    .operandValid(opv[1]), .operandReady(opr[1]), .Result(res[1]),
    .CarryCount(cc_b), .Overflow(ov[1]), .resultValid(rv[1]),
    .resultReady(rr[1]), .busy(busy[1]));

  carry_accumulator #(.WIDTH(16), .COUNT(1), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .operand(op[2]),
    .operandValid(opv[2]), .operandReady(opr[2]), .Result(res[2]),
    .CarryCount(cc[2]), .Overflow(ov[2]), .resultValid(rv[2]),
    .resultReady(rr[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: expected accumulator after each handshake, and expected
  // final {Result, CarryCount, Overflow} per completed burst.
  logic [15:0] acc_q[$];
  logic [24:0] res_q[$];

  logic pending [3];
  logic prev_rv [3];
  int   age     [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      pending[k] = 1'b0;
      prev_rv[k] = 1'b0;
      age[k]     = 100;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        pending[k] = 1'b0;
        prev_rv[k] = 1'b0;
        age[k]     = 100;
      end else begin
        age[k]++;
        if (pending[k]) begin
          if (acc_q.size() == 0) check("acc_q_underflow", 1, 0);
          else                   check("acc_after_hs", {16'h0, res[k]}, {16'h0, acc_q.pop_front()});
          pending[k] = 1'b0;
        end
        if (rv[k] && !prev_rv[k]) check("result_latency", age[k], 1);
        if (rv[k] && rr[k]) begin
          if (res_q.size() == 0) check("res_q_underflow", 1, 0);
          else check("final_result", {7'h0, res[k], cc[k], ov[k]}, {7'h0, res_q.pop_front()});
        end
        prev_rv[k] = rv[k];
        if (opv[k] && opr[k]) begin
          pending[k] = 1'b1;
          age[k]     = 0;
        end
      end
    end
  end

  // All driving tasks are entered and left at posedge+1.
  task automatic start_burst(input int k);
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [15:0] v, input logic [15:0] exp_acc);
    int n = 0;
    op[k]  = v;
    opv[k] = 1'b1;
    acc_q.push_back(exp_acc);
    @(negedge clk);
    while (!opr[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!opr[k]) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    opv[k] = 1'b0;
    op[k]  = 16'hxxxx;
  endtask

  task automatic bubbles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic finish_burst(input int k);
    int n = 0;
    @(negedge clk);
    while (!rv[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'h0, rv[k]}, 1);
    @(negedge clk);
    check("idle_after_done", {30'h0, rv[k], busy[k]}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      op[k]    = 16'h0;
      opv[k]   = 1'b0;
      rr[k]    = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++)
      check("reset_state", {4'h0, res[k], cc[k], ov[k], rv[k], opr[k], busy[k]}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic burst, no bubbles.
    start_burst(0);
    res_q.push_back({16'h8F28, 8'd2, 1'b0});
    send(0, 16'hA0A0, 16'hA0A0);
    send(0, 16'hA0A0, 16'h4140);
    send(0, 16'h58F4, 16'h9A34);
    send(0, 16'hF4F4, 16'h8F28);
    finish_burst(0);

    // Same burst with 3-cycle bubbles.
    start_burst(0);
    res_q.push_back({16'h8F28, 8'd2, 1'b0});
    send(0, 16'hA0A0, 16'hA0A0); bubbles(3);
    send(0, 16'hA0A0, 16'h4140); bubbles(3);
    send(0, 16'h58F4, 16'h9A34); bubbles(3);
    send(0, 16'hF4F4, 16'h8F28);
    finish_burst(0);

    // Backpressure in DONE, with start held (must be ignored).
    rr[0] = 1'b0;
    start_burst(0);
    res_q.push_back({16'h8F28, 8'd2, 1'b0});
    send(0, 16'hA0A0, 16'hA0A0);
    send(0, 16'hA0A0, 16'h4140);
    send(0, 16'h58F4, 16'h9A34);
    send(0, 16'hF4F4, 16'h8F28);
    start[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {res[0], cc[0], ov[0], rv[0], opr[0], busy[0], 4'h0},
                       {16'h8F28, 8'd2, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0});
      @(posedge clk); #1;
    end
    rr[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(negedge clk);
    check("bp_start_ignored", {29'h0, rv[0], opr[0], busy[0]}, 0);
    @(posedge clk); #1;

    // Reset mid-burst after the 2nd handshake.
    start_burst(0);
    send(0, 16'hA0A0, 16'hA0A0);
    send(0, 16'hA0A0, 16'h4140);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", {4'h0, res[0], cc[0], ov[0], rv[0], opr[0], busy[0]}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_burst(0);
    res_q.push_back({16'h1E4C, 8'd0, 1'b0});
    send(0, 16'h0F3D, 16'h0F3D);
    send(0, 16'h0F0F, 16'h1E4C);
    send(0, 16'h0000, 16'h1E4C);
    send(0, 16'h0000, 16'h1E4C);
    finish_burst(0);

    // Carry saturation: CNT_W=2, COUNT=5.
    start_burst(1);
    res_q.push_back({16'hFFFB, 8'd3, 1'b1});
    send(1, 16'hFFFF, 16'hFFFF);
    send(1, 16'hFFFF, 16'hFFFE);
    send(1, 16'hFFFF, 16'hFFFD);
    send(1, 16'hFFFF, 16'hFFFC);
    send(1, 16'hFFFF, 16'hFFFB);
    finish_burst(1);

    // COUNT=1.
    start_burst(2);
    res_q.push_back({16'hC8CA, 8'd0, 1'b0});
    send(2, 16'hC8CA, 16'hC8CA);
    finish_burst(2);

    n = 0;
    repeat (3) @(negedge clk);
    check("acc_q_drained", acc_q.size(), n);
    check("res_q_drained", res_q.size(), n);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
